// File: rtl/dac_seq_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dac_seq_ctrl_if                                        |
// | Description : Control, stream and DAC pin bundle for dac_seq_ctrl.   |
// |               slave = controller side, master = host/driver side.    |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
interface dac_seq_ctrl_if;
  logic        en_req;
  logic        cpu_wr;
  logic [9:0]  cpu_data;
  logic        stream_en;
  logic [15:0] rate_div;
  logic        samp_valid;
  logic [9:0]  samp_data;
  logic        samp_ready;
  logic        underrun_clr;
  logic        dac_en;
  logic [9:0]  dac_d;
  logic        dac_ready;
  logic        underrun;

  modport master (
    output en_req, cpu_wr, cpu_data, stream_en, rate_div,
           samp_valid, samp_data, underrun_clr,
    input  samp_ready, dac_en, dac_d, dac_ready, underrun
  );

  modport slave (
    input  en_req, cpu_wr, cpu_data, stream_en, rate_div,
           samp_valid, samp_data, underrun_clr,
    output samp_ready, dac_en, dac_d, dac_ready, underrun
  );
endinterface
`default_nettype wire

// File: rtl/dac_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dac_seq_ctrl                                           |
// | Description : DAC power sequencer (OFF/SETTLE/ON) with a sample FIFO |
// |               played back at a programmable rate, plus direct CPU    |
// |               code writes that take priority over playback.          |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module dac_seq_ctrl #(
  parameter int SETTLE_CYCLES = 100,  // 1..65535
  parameter int FIFO_DEPTH    = 4     // power of two, 2..16
) (
  input  wire logic     clk,
  input  wire logic     reset,
  dac_seq_ctrl_if.slave bus
);

  localparam int          AW          = $clog2(FIFO_DEPTH);
  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_OFF    = 2'd0,
    S_SETTLE = 2'd1,
    S_ON     = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] settle_q, settle_d;
  logic [15:0] per_q, per_d;
  logic        run_q, run_d;
  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  logic [9:0]  code_q, code_d;
  logic        underrun_q, underrun_d;
  logic [9:0]  mem_q [FIFO_DEPTH];

  logic run, start, tick, cpu_ok, flush, empty, full, push, pop, ur_set;

  // FIFO status; the extra pointer bit separates full from empty
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

  // Playback pacing: a fresh run (stream_en rising or entering ON) reloads
  // the period counter and suppresses the tick in that first cycle.
  assign run    = (state_q == S_ON) && bus.stream_en;
  assign start  = run && !run_q;
  assign tick   = run && !start && (per_q == 16'd0);
  assign cpu_ok = (state_q == S_ON) && bus.cpu_wr;

  // Flushing on the edge into OFF leaves the FIFO empty in the first OFF cycle
  assign flush  = (state_d == S_OFF);
  assign push   = bus.samp_valid && bus.samp_ready && !flush;
  assign pop    = tick && !cpu_ok && !empty;
  assign ur_set = tick && !cpu_ok && empty;

  // Next-state and settle counter
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    case (state_q)
      S_OFF: begin
        if (bus.en_req) begin
          state_d  = S_SETTLE;
          settle_d = SETTLE_LOAD;
        end
      end
      S_SETTLE: begin
        if (settle_q == 16'd0) begin
          state_d = S_ON;
        end else begin
          settle_d = settle_q - 16'd1;
        end
      end
      S_ON: begin
        state_d = S_ON;
      end
      default: begin
        state_d = S_OFF;
      end
    endcase
    if (!bus.en_req) begin
      state_d  = S_OFF;
      settle_d = 16'd0;
    end
  end

  // Datapath next values: period counter, FIFO pointers, DAC code, underrun
  always_comb begin
    run_d = run;
    per_d = per_q;
    if (!run) begin
      per_d = 16'd0;
    end else if (start || (per_q == 16'd0)) begin
      per_d = bus.rate_div;
    end else begin
      per_d = per_q - 16'd1;
    end

    wr_d = wr_q;
    rd_d = rd_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_q + 1'b1;
    end

    code_d = code_q;
    if (flush) begin
      code_d = 10'd0;
    end else if (cpu_ok) begin
      code_d = bus.cpu_data;
    end else if (pop) begin
      code_d = mem_q[rd_q[AW-1:0]];
    end

    underrun_d = underrun_q;
    if (ur_set) begin
      underrun_d = 1'b1;
    end else if (bus.underrun_clr) begin
      underrun_d = 1'b0;
    end
  end

  // State and control registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_OFF;
      settle_q   <= 16'd0;
      per_q      <= 16'd0;
      run_q      <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      code_q     <= 10'd0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      per_q      <= per_d;
      run_q      <= run_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      code_q     <= code_d;
      underrun_q <= underrun_d;
    end
  end

  // Sample storage; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q[AW-1:0]] <= bus.samp_data;
    end
  end

  assign bus.dac_en     = (state_q != S_OFF);
  assign bus.dac_ready  = (state_q == S_ON);
  assign bus.samp_ready = (state_q != S_OFF) && !full;
  assign bus.dac_d      = code_q;
  assign bus.underrun   = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_dac_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_dac_seq_ctrl                                        |
// | Description : Directed self-checking bench for dac_seq_ctrl.         |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_dac_seq_ctrl;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;

  dac_seq_ctrl_if bus ();

  dac_seq_ctrl #(
    .SETTLE_CYCLES (100),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en"},   32'(bus.dac_en),     32'd0);
    chk({tag, "_d"},    32'(bus.dac_d),      32'd0);
    chk({tag, "_rdy"},  32'(bus.dac_ready),  32'd0);
    chk({tag, "_srdy"}, 32'(bus.samp_ready), 32'd0);
    chk({tag, "_ur"},   32'(bus.underrun),   32'd0);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b1;
    bus.en_req       = 1'b0;
    bus.cpu_wr       = 1'b0;
    bus.cpu_data     = 10'd0;
    bus.stream_en    = 1'b0;
    bus.rate_div     = 16'd0;
    bus.samp_valid   = 1'b0;
    bus.samp_data    = 10'd0;
    bus.underrun_clr = 1'b0;

    // Reset values
    #1;
    chk_all_zero("rst");
    step(2);
    reset = 1'b0;
    step(2);
    chk("idle_en", 32'(bus.dac_en), 32'd0);

    // Power-up: dac_en one clock after en_req, ready 100 clocks after dac_en
    bus.en_req = 1'b1;
    step(1);
    chk("settle_en",   32'(bus.dac_en),     32'd1);
    chk("settle_rdy",  32'(bus.dac_ready),  32'd0);
    chk("settle_srdy", 32'(bus.samp_ready), 32'd1);
    step(99);
    chk("settle_99", 32'(bus.dac_ready), 32'd0);
    step(1);
    chk("settle_100", 32'(bus.dac_ready), 32'd1);

    // Paced playback at rate_div=3
    bus.samp_valid = 1'b1;
    bus.samp_data  = 10'h3FF; step(1);
    bus.samp_data  = 10'h000; step(1);
    bus.samp_data  = 10'h155; step(1);
    bus.samp_valid = 1'b0;
    bus.rate_div   = 16'd3;
    bus.stream_en  = 1'b1;
    step(4);
    chk("pb_pre", 32'(bus.dac_d), 32'h000);
    step(1);
    chk("pb_s0", 32'(bus.dac_d), 32'h3FF);
    step(4);
    chk("pb_s1", 32'(bus.dac_d), 32'h000);
    step(4);
    chk("pb_s2", 32'(bus.dac_d), 32'h155);
    step(3);
    chk("pb_ur_pre", 32'(bus.underrun), 32'd0);
    step(1);
    chk("pb_ur_set", 32'(bus.underrun), 32'd1);
    chk("pb_hold",   32'(bus.dac_d),    32'h155);

    // Set and clear on the same tick: set wins; clear alone then clears
    step(3);
    bus.underrun_clr = 1'b1;
    step(1);
    chk("ur_set_wins", 32'(bus.underrun), 32'd1);
    step(1);
    chk("ur_clr", 32'(bus.underrun), 32'd0);
    bus.underrun_clr = 1'b0;

    // cpu_wr on a tick cycle beats the FIFO head
    bus.samp_valid = 1'b1;
    bus.samp_data  = 10'h0AA;
    step(1);
    bus.samp_valid = 1'b0;
    step(1);
    bus.cpu_wr   = 1'b1;
    bus.cpu_data = 10'h200;
    step(1);
    bus.cpu_wr = 1'b0;
    chk("cpu_win",    32'(bus.dac_d),    32'h200);
    chk("cpu_no_ur",  32'(bus.underrun), 32'd0);
    step(3);
    chk("cpu_hold",   32'(bus.dac_d),    32'h200);
    step(1);
    chk("cpu_next",   32'(bus.dac_d),    32'h0AA);

    // Fill with playback frozen: 4 accepted, 5th held off
    bus.stream_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("fill_srdy", 32'(bus.samp_ready), 32'd1);
      bus.samp_valid = 1'b1;
      bus.samp_data  = 10'(i + 1);
      step(1);
    end
    chk("full_srdy", 32'(bus.samp_ready), 32'd0);
    bus.samp_data = 10'h005;
    step(1);
    bus.samp_valid = 1'b0;
    chk("full_hold",   32'(bus.samp_ready), 32'd0);
    chk("freeze_hold", 32'(bus.dac_d),      32'h0AA);

    // Drain at rate_div=0 (tick every cycle); 5th sample must be absent
    bus.rate_div  = 16'd0;
    bus.stream_en = 1'b1;
    step(2);
    chk("r0_s1", 32'(bus.dac_d), 32'h001);
    step(1);
    chk("r0_s2", 32'(bus.dac_d), 32'h002);
    step(1);
    chk("r0_s3", 32'(bus.dac_d), 32'h003);
    step(1);
    chk("r0_s4", 32'(bus.dac_d), 32'h004);
    chk("r0_ur0", 32'(bus.underrun), 32'd0);
    step(1);
    chk("r0_ur1", 32'(bus.underrun), 32'd1);
    chk("r0_hold", 32'(bus.dac_d), 32'h004);
    bus.stream_en = 1'b0;

    // Power-down from ON
    bus.en_req = 1'b0;
    step(1);
    chk("off_en", 32'(bus.dac_en), 32'd0);
    chk("off_d",  32'(bus.dac_d),  32'd0);

    // Drop en_req mid-SETTLE with two samples buffered
    bus.en_req = 1'b1;
    step(1);
    chk("s2_en", 32'(bus.dac_en), 32'd1);
    bus.samp_valid = 1'b1;
    bus.samp_data  = 10'h111; step(1);
    bus.samp_data  = 10'h222; step(1);
    bus.samp_valid = 1'b0;
    bus.cpu_wr   = 1'b1;
    bus.cpu_data = 10'h123;
    step(1);
    bus.cpu_wr = 1'b0;
    chk("settle_cpu_ign", 32'(bus.dac_d), 32'd0);
    bus.en_req = 1'b0;
    step(1);
    chk("abort_en",   32'(bus.dac_en),     32'd0);
    chk("abort_d",    32'(bus.dac_d),      32'd0);
    chk("abort_srdy", 32'(bus.samp_ready), 32'd0);

    // Re-enable: full settle wait, then FIFO proves empty
    bus.underrun_clr = 1'b1;
    bus.en_req       = 1'b1;
    step(1);
    bus.underrun_clr = 1'b0;
    chk("re_ur_clr", 32'(bus.underrun), 32'd0);
    step(99);
    chk("re_99", 32'(bus.dac_ready), 32'd0);
    step(1);
    chk("re_100", 32'(bus.dac_ready), 32'd1);
    bus.rate_div  = 16'd0;
    bus.stream_en = 1'b1;
    step(1);
    chk("flush_ur0", 32'(bus.underrun), 32'd0);
    step(1);
    chk("flush_empty", 32'(bus.underrun), 32'd1);
    chk("flush_d",     32'(bus.dac_d),    32'd0);

    // Asynchronous reset mid-stream
    bus.stream_en = 1'b0;
    bus.cpu_wr    = 1'b1;
    bus.cpu_data  = 10'h3C3;
    step(1);
    bus.cpu_wr = 1'b0;
    chk("pre_rst_d", 32'(bus.dac_d), 32'h3C3);
    bus.stream_en = 1'b1;
    step(2);
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("arst");
    bus.en_req    = 1'b0;
    bus.stream_en = 1'b0;
    step(2);
    reset = 1'b0;
    step(1);
    chk("post_rst_en", 32'(bus.dac_en), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dac_seq_ctrl.md
DAC_SEQ_CTRL -- requirements
Module: dac_seq_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 100: clocks from dac_en rising to DAC ready; legal range 1..65535.
REQ-002 Parameter FIFO_DEPTH, default 4: sample buffer entries; power of two, 2..16.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 en_req  input  1  level request to power the DAC.
REQ-006 cpu_wr  input  1  one-cycle strobe for a direct code write.
REQ-007 cpu_data  input  10  direct DAC code.
REQ-008 stream_en  input  1  level enable for paced playback from the FIFO.
REQ-009 rate_div  input  16  playback period in clocks, minus one.
REQ-010 samp_valid  input  1  stream sample offered.
REQ-011 samp_data  input  10  stream sample code.
REQ-012 samp_ready  output  1  FIFO can accept a sample (not full).
REQ-013 underrun_clr  input  1  clears the underrun flag.
REQ-014 dac_en  output  1  drives the DAC EN pin.
REQ-015 dac_d  output  10  drives the DAC D[9:0] bus.
REQ-016 dac_ready  output  1  DAC powered and settled.
REQ-017 underrun  output  1  sticky flag: a playback tick found the FIFO empty.

Function
REQ-018 The FSM SHALL have three states: OFF, SETTLE and ON.
REQ-019 OFF->SETTLE SHALL occur when en_req=1; in SETTLE, dac_en=1 and a counter loads SETTLE_CYCLES-1.
REQ-020 SETTLE->ON SHALL occur on the cycle the counter reaches 0; dac_ready=1 only in ON.
REQ-021 Any state SHALL go ->OFF in the cycle after en_req=0; in OFF, dac_en=0 and dac_d=0.
REQ-022 In OFF the FIFO SHALL flush, and the flush SHALL also cover en_req dropping during SETTLE.
REQ-023 FIFO push SHALL occur when samp_valid & samp_ready; samp_ready=0 when the FIFO is full or the state is OFF.
REQ-024 In SETTLE, pushes SHALL be accepted but no pops SHALL occur.
REQ-025 In ON with stream_en=1, a period counter SHALL count rate_div down to 0, then reload; a tick is the cycle it equals 0.
REQ-026 rate_div=0 SHALL produce a tick every cycle.
REQ-027 A tick with the FIFO non-empty SHALL pop the head, with dac_d taking its value the next cycle.
REQ-028 A tick with the FIFO empty SHALL set underrun=1 and leave dac_d unchanged.
REQ-029 underrun_clr SHALL clear underrun; if a set and a clear occur in the same cycle, the set wins.
REQ-030 In ON, cpu_wr SHALL load cpu_data into dac_d the next cycle, regardless of stream_en.
REQ-031 If cpu_wr and a tick coincide, cpu_wr SHALL win: no pop, the sample stays at the head, no underrun, and the period counter reloads normally.
REQ-032 cpu_wr in OFF or SETTLE SHALL be ignored.
REQ-033 A simultaneous push and pop on a full FIFO SHALL be disallowed because samp_ready=0; a simultaneous push and pop otherwise SHALL keep the count unchanged.
REQ-034 A stream_en 0->1 transition SHALL reload the period counter, so the first tick occurs rate_div+1 clocks later.
REQ-035 A stream_en 1->0 transition SHALL freeze the FIFO and hold dac_d.
REQ-036 FIFO pointers SHALL wrap modulo FIFO_DEPTH, and full/empty SHALL be distinguished by an extra pointer bit.

Reset
REQ-037 While reset=1, asynchronously: state OFF, dac_en=0, dac_d=0, dac_ready=0, samp_ready=0, underrun=0, FIFO empty, and all counters 0.
REQ-038 After reset deassertion, the block SHALL enter SETTLE no earlier than the first clock edge with en_req=1.

Verification
REQ-039 en_req=1 with SETTLE_CYCLES=100 -> dac_en rises 1 clock later and dac_ready rises exactly 100 clocks after dac_en.
REQ-040 ON, stream_en=1, rate_div=3, push 0x3FF,0x000,0x155 -> dac_d steps through those values every 4 clocks; the 4th tick sets underrun, and dac_d holds 0x155.
REQ-041 ON, cpu_wr=1 with data 0x200 on the same cycle as a tick, FIFO head 0x0AA -> dac_d=0x200; the next tick outputs 0x0AA.
REQ-042 Push 5 samples with FIFO_DEPTH=4 and no playback -> samp_ready drops after the 4th push, and the 5th sample is held off.
REQ-043 en_req drops mid-SETTLE with 2 samples buffered -> next cycle: OFF, dac_en=0, dac_d=0, FIFO empty; re-enable -> a full SETTLE_CYCLES wait.
REQ-044 reset asserted asynchronously in ON mid-stream -> all outputs reach reset values before the next clock edge; underrun set and underrun_clr in the same cycle -> underrun remains 1.
